// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: loader tokens,
// controller state enumeration and a byte-lane insertion helper.
package imem_pkg;

    localparam logic [7:0] TOKEN_START = 8'hFE;
    localparam logic [7:0] TOKEN_END   = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_DONE,
        ST_ERROR
    } load_state_e;

    // Place a byte into a word, lane 0 being the most significant byte.
    function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [7:0]  data);
        logic [31:0] result;
        result = word;
        case (lane)
            2'd0:    result[31:24] = data;
            2'd1:    result[23:16] = data;
            2'd2:    result[15:8]  = data;
            default: result[7:0]   = data;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Byte-lane assembler: collects loader bytes MSB-first into a 32-bit word.
// Unfilled lanes always read as zero, so the held word doubles as the
// zero-padded partial word when the image ends mid-word.
module imem_word_packer
    import imem_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear_i,
    input  logic        push_i,
    input  logic [7:0]  byte_i,
    output logic [1:0]  lane_o,
    output logic [31:0] word_o,
    output logic [31:0] word_next_o
);

    logic [1:0]  lane_q, lane_d;
    logic [31:0] word_q, word_d;

    assign lane_o      = lane_q;
    assign word_o      = word_q;
    assign word_next_o = insert_byte(word_q, lane_q, byte_i);

    // Advance the lane on each pushed byte; a completed word restarts empty.
    always_comb begin
        lane_d = lane_q;
        word_d = word_q;
        if (clear_i) begin
            lane_d = 2'd0;
            word_d = '0;
        end else if (push_i) begin
            if (lane_q == 2'd3) begin
                lane_d = 2'd0;
                word_d = '0;
            end else begin
                lane_d = lane_q + 2'd1;
                word_d = word_next_o;
            end
        end
    end

    // Lane and partial-word registers; reset abandons any partial word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane_q <= 2'd0;
            word_q <= '0;
        end else begin
            lane_q <= lane_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/imem_load_ctrl.sv
// Instruction-memory load controller: receives a byte-stream image framed
// by 0xFE / 0xFF, writes full words into instruction memory and holds the
// core in reset until a load completes cleanly.
module imem_load_ctrl
    import imem_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int AW          = 6,
    parameter int TIMEOUT_CYC = 1048575
)(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [31:0]   mem_wdata,
    output logic          cpu_rst_n,
    output logic          load_busy,
    output logic          load_done,
    output logic          load_err,
    output logic [AW:0]   word_count
);

    localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    load_state_e   state_q, state_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_waddr_q, mem_waddr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [AW:0]   word_count_q, word_count_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic          accept;
    logic          pack_clear;
    logic          pack_push;
    logic [1:0]    pack_lane;
    logic [31:0]   pack_word;
    logic [31:0]   pack_word_next;

    imem_word_packer u_packer (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear_i     (pack_clear),
        .push_i      (pack_push),
        .byte_i      (byte_data),
        .lane_o      (pack_lane),
        .word_o      (pack_word),
        .word_next_o (pack_word_next)
    );

    assign accept     = byte_valid && byte_ready;
    assign byte_ready = (state_q == ST_IDLE) || ((state_q == ST_LOAD) && !mem_we_q);
    assign mem_we     = mem_we_q;
    assign mem_waddr  = mem_waddr_q;
    assign mem_wdata  = mem_wdata_q;
    assign word_count = word_count_q;
    assign cpu_rst_n  = (state_q == ST_DONE);
    assign load_busy  = (state_q == ST_LOAD) || (state_q == ST_FLUSH);
    assign load_done  = (state_q == ST_DONE);
    assign load_err   = (state_q == ST_ERROR);

    // Next-state logic: token decoding, word writes, overflow and idle timeout.
    // In DONE/ERROR the restart token is sampled without a handshake, so the
    // loader presents it for a single cycle.
    always_comb begin
        state_d      = state_q;
        mem_we_d     = 1'b0;
        mem_waddr_d  = mem_waddr_q;
        mem_wdata_d  = mem_wdata_q;
        word_count_d = word_count_q;
        tmo_d        = '0;
        pack_clear   = 1'b0;
        pack_push    = 1'b0;

        if (mem_we_q) begin
            word_count_d = word_count_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept && (byte_data == TOKEN_START)) begin
                    state_d      = ST_LOAD;
                    pack_clear   = 1'b1;
                    word_count_d = '0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    if (byte_data == TOKEN_END) begin
                        pack_clear = 1'b1;
                        if (pack_lane == 2'd0) begin
                            state_d = ST_DONE;
                        end else if (word_count_q == DEPTH_W) begin
                            state_d = ST_ERROR;
                        end else begin
                            state_d     = ST_FLUSH;
                            mem_we_d    = 1'b1;
                            mem_waddr_d = word_count_q[AW-1:0];
                            mem_wdata_d = pack_word;
                        end
                    end else begin
                        pack_push = 1'b1;
                        if (pack_lane == 2'd3) begin
                            if (word_count_q == DEPTH_W) begin
                                state_d = ST_ERROR;
                            end else begin
                                mem_we_d    = 1'b1;
                                mem_waddr_d = word_count_q[AW-1:0];
                                mem_wdata_d = pack_word_next;
                            end
                        end
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_ERROR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_FLUSH: begin
                state_d = ST_DONE;
            end
            ST_DONE, ST_ERROR: begin
                if (byte_valid && (byte_data == TOKEN_START)) begin
                    state_d      = ST_LOAD;
                    pack_clear   = 1'b1;
                    word_count_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, write-port and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            mem_we_q     <= 1'b0;
            mem_waddr_q  <= '0;
            mem_wdata_q  <= '0;
            word_count_q <= '0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            mem_we_q     <= mem_we_d;
            mem_waddr_q  <= mem_waddr_d;
            mem_wdata_q  <= mem_wdata_d;
            word_count_q <= word_count_d;
            tmo_q        <= tmo_d;
        end
    end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Bench for imem_load_ctrl: random and directed images, with expected
// memory writes computed from the byte stream by plain arithmetic.
module tb_imem_load_ctrl;
    import imem_pkg::*;

    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int TMO   = 16;

    logic          clk;
    logic          reset_n;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic          cpu_rst_n;
    logic          load_busy;
    logic          load_done;
    logic          load_err;
    logic [AW:0]   word_count;

    int checks = 0;
    int errors = 0;

    logic [7:0]     imgQ[$];
    logic [AW+31:0] obsQ[$];

    imem_load_ctrl #(
        .DEPTH       (DEPTH),
        .AW          (AW),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .cpu_rst_n  (cpu_rst_n),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .load_err   (load_err),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Record every memory write, and check byte_ready drops only on writes
    // while loading and is low outside IDLE otherwise.
    always @(negedge clk) begin
        if (mem_we) obsQ.push_back({mem_waddr, mem_wdata});
        checkOutput("readyRule", byte_ready,
                    load_busy ? !mem_we : !(load_done || load_err));
    end

    // Offer one byte from a negedge and hold it until handshaked.
    task automatic applyStimulus(input logic [7:0] b);
        int waitCyc;
        waitCyc    = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && waitCyc < 50) begin
            @(negedge clk);
            waitCyc++;
        end
        checkOutput("byteAccept", byte_ready, 1'b1);
        if (byte_ready) begin
            @(posedge clk);
            @(negedge clk);
        end
        byte_valid = 1'b0;
    endtask

    task automatic restartPulse();
        byte_valid = 1'b1;
        byte_data  = TOKEN_START;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic fillRandom(input int n);
        imgQ.delete();
        repeat (n) imgQ.push_back(8'($urandom_range(0, 254)));
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ready"}, byte_ready, 1'b1);
        checkOutput({tag, "_we"}, mem_we, 1'b0);
        checkOutput({tag, "_waddr"}, mem_waddr, 0);
        checkOutput({tag, "_wdata"}, mem_wdata, 0);
        checkOutput({tag, "_count"}, word_count, 0);
        checkOutput({tag, "_cpuRst"}, cpu_rst_n, 1'b0);
        checkOutput({tag, "_busy"}, load_busy, 1'b0);
        checkOutput({tag, "_done"}, load_done, 1'b0);
        checkOutput({tag, "_err"}, load_err, 1'b0);
    endtask

    // Run one load of imgQ and compare writes and end state with the model.
    task automatic runImage(input bit sendEnd, input bit backToBack, input string tag);
        int nBytes;
        int full;
        int rem;
        bit overflow;
        int expWrites;
        int n;
        int idx;
        logic [31:0] expWord;
        nBytes   = imgQ.size();
        full     = nBytes / 4;
        rem      = nBytes % 4;
        overflow = (full > DEPTH);
        expWrites = overflow ? DEPTH : full + ((sendEnd && rem != 0) ? 1 : 0);
        obsQ.delete();
        if (load_done || load_err) restartPulse();
        else applyStimulus(TOKEN_START);
        checkOutput({tag, "_startBusy"}, load_busy, 1'b1);
        checkOutput({tag, "_startHold"}, cpu_rst_n, 1'b0);
        checkOutput({tag, "_startCount"}, word_count, 0);
        foreach (imgQ[i]) begin
            applyStimulus(imgQ[i]);
            if (!backToBack) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        if (sendEnd) applyStimulus(TOKEN_END);
        n = 0;
        while (!(load_done || load_err) && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_done"}, load_done, !overflow);
        checkOutput({tag, "_err"}, load_err, overflow);
        checkOutput({tag, "_cpuRst"}, cpu_rst_n, !overflow);
        checkOutput({tag, "_count"}, word_count, expWrites);
        checkOutput({tag, "_nWrites"}, obsQ.size(), expWrites);
        for (int w = 0; w < expWrites && w < obsQ.size(); w++) begin
            expWord = '0;
            for (int l = 0; l < 4; l++) begin
                idx = w * 4 + l;
                if (idx < nBytes) expWord = expWord | (32'(imgQ[idx]) << (24 - 8 * l));
            end
            checkOutput({tag, "_write"}, obsQ[w], {AW'(w), expWord});
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n    = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        reset_n = 1'b1;
        @(negedge clk);

        applyStimulus(8'h12);
        applyStimulus(8'hFF);
        checkOutput("idleJunk_busy", load_busy, 1'b0);
        checkOutput("idleJunk_ready", byte_ready, 1'b1);

        imgQ = '{8'h11, 8'h22, 8'h33, 8'h44};
        runImage(1'b1, 1'b0, "oneWord");

        imgQ = '{8'hAA, 8'hBB};
        runImage(1'b1, 1'b0, "flush");

        for (int k = 0; k < 3; k++) begin
            fillRandom($urandom_range(1, 40));
            runImage(1'b1, 1'b0, "rand");
        end

        fillRandom(4 * DEPTH);
        runImage(1'b1, 1'b1, "full64");

        fillRandom(4 * (DEPTH + 1));
        runImage(1'b0, 1'b1, "overflow");

        restartPulse();
        checkOutput("tmo_busy", load_busy, 1'b1);
        applyStimulus(8'h01);
        repeat (TMO - 1) @(negedge clk);
        checkOutput("tmo_notYet", load_err, 1'b0);
        @(negedge clk);
        checkOutput("tmo_err", load_err, 1'b1);
        checkOutput("tmo_cpuRst", cpu_rst_n, 1'b0);

        imgQ = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h5A};
        runImage(1'b1, 1'b0, "afterTmo");

        restartPulse();
        obsQ.delete();
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        reset_n = 1'b0;
        #1;
        checkResetValues("midReset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("midReset_noWrite", obsQ.size(), 0);
        checkOutput("midReset_idle", load_busy, 1'b0);
        checkOutput("midReset_count", word_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
